// File: rtl/fallthrough_fifo_stat_if.sv
// Handshake and status bundle for fallthrough_fifo_stat.
// parity_err exists only when FALLTHROUGH_FIFO_PARITY_EN is defined.
interface fallthrough_fifo_stat_if #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3
);
  logic [WIDTH-1:0]        din;
  logic                    wr_en;
  logic                    rd_en;
  logic                    err_clr;
  logic [WIDTH-1:0]        dout;
  logic                    full;
  logic                    nearly_full;
  logic                    prog_full;
  logic                    empty;
  logic                    prog_empty;
  logic [MAX_DEPTH_BITS:0] data_count;
  logic                    overflow;
  logic                    underflow;
`ifdef FALLTHROUGH_FIFO_PARITY_EN
  logic                    parity_err;
`endif

  modport master (
`ifdef FALLTHROUGH_FIFO_PARITY_EN
    input  parity_err,
`endif
    output din, wr_en, rd_en, err_clr,
    input  dout, full, nearly_full, prog_full, empty, prog_empty,
           data_count, overflow, underflow
  );

  modport slave (
`ifdef FALLTHROUGH_FIFO_PARITY_EN
    output parity_err,
`endif
    input  din, wr_en, rd_en, err_clr,
    output dout, full, nearly_full, prog_full, empty, prog_empty,
           data_count, overflow, underflow
  );
endinterface

// File: rtl/fallthrough_fifo_stat.sv
// Fall-through FIFO with occupancy count, programmable thresholds and sticky errors.
// Optional per-entry even parity enabled by FALLTHROUGH_FIFO_PARITY_EN.
module fallthrough_fifo_stat #(
  parameter int WIDTH                = 72,
  parameter int MAX_DEPTH_BITS       = 3,
  parameter int PROG_FULL_THRESHOLD  = (1 << MAX_DEPTH_BITS) - 1,
  parameter int PROG_EMPTY_THRESHOLD = 1
) (
  input logic                   clk,
  input logic                   reset_n,
  fallthrough_fifo_stat_if.slave bus
);
  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam int CW    = MAX_DEPTH_BITS + 1;
`ifdef FALLTHROUGH_FIFO_PARITY_EN
  localparam int EW    = WIDTH + 1;
`else
  localparam int EW    = WIDTH;
`endif
  localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
  localparam logic [CW-1:0] PfullC  = CW'(PROG_FULL_THRESHOLD);
  localparam logic [CW-1:0] PemptyC = CW'(PROG_EMPTY_THRESHOLD);

  logic [EW-1:0]             mem_q [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      overflow_q, overflow_d;
  logic                      underflow_q, underflow_d;
  logic                      wrAccept, rdAccept, isFull, isEmpty;
  logic [EW-1:0]             wrEntry, headEntry;

  // A write at full is only taken when a read frees the head slot in the same edge.
  always_comb begin
    isFull      = (count_q == DepthC);
    isEmpty     = (count_q == '0);
    wrAccept    = bus.wr_en && (!isFull || bus.rd_en);
    rdAccept    = bus.rd_en && !isEmpty;
    wr_ptr_d    = wrAccept ? wr_ptr_q + MAX_DEPTH_BITS'(1) : wr_ptr_q;
    rd_ptr_d    = rdAccept ? rd_ptr_q + MAX_DEPTH_BITS'(1) : rd_ptr_q;
    count_d     = count_q + CW'(wrAccept) - CW'(rdAccept);
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (bus.wr_en && !wrAccept) overflow_d = 1'b1;
    if (bus.rd_en && isEmpty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef FALLTHROUGH_FIFO_PARITY_EN
  assign wrEntry = {^bus.din, bus.din};
`else
  assign wrEntry = bus.din;
`endif

  always_ff @(posedge clk) begin
    if (wrAccept) mem_q[wr_ptr_q] <= wrEntry;
  end

  assign headEntry       = mem_q[rd_ptr_q];
  assign bus.dout        = headEntry[WIDTH-1:0];
  assign bus.full        = isFull;
  assign bus.nearly_full = (count_q >= DepthC - CW'(1));
  assign bus.prog_full   = (count_q >= PfullC);
  assign bus.empty       = isEmpty;
  assign bus.prog_empty  = (count_q <= PemptyC);
  assign bus.data_count  = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
`ifdef FALLTHROUGH_FIFO_PARITY_EN
  assign bus.parity_err  = !isEmpty && (headEntry[WIDTH] != ^headEntry[WIDTH-1:0]);
`endif
endmodule

// File: tb/tb_fallthrough_fifo_stat.sv
// Self-checking bench for fallthrough_fifo_stat against a queue-based reference model.
module tb_fallthrough_fifo_stat;
  localparam int W     = 32;
  localparam int DB    = 3;
  localparam int DEPTH = 8;
  localparam logic [10:0] ResetStatus = 11'b000_11_0000_00;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  logic [W-1:0] q[$];
  logic         ovfM = 1'b0;
  logic         udfM = 1'b0;

  fallthrough_fifo_stat_if #(.WIDTH(W), .MAX_DEPTH_BITS(DB)) bus();

  fallthrough_fifo_stat #(
    .WIDTH(W), .MAX_DEPTH_BITS(DB),
    .PROG_FULL_THRESHOLD(4), .PROG_EMPTY_THRESHOLD(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if something stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Status flags expected from the model occupancy and sticky bits
  function automatic logic [10:0] expStatus();
    int n;
    n = q.size();
    return {n == DEPTH, n >= DEPTH - 1, n >= 4, n == 0, n <= 1, 4'(n), ovfM, udfM};
  endfunction

  function automatic logic [10:0] actStatus();
    return {bus.full, bus.nearly_full, bus.prog_full, bus.empty, bus.prog_empty,
            bus.data_count, bus.overflow, bus.underflow};
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, then idle inputs
  task automatic applyStimulus(input logic wr, input logic rd, input logic clr,
                               input logic [W-1:0] d);
    int   n;
    logic wOk, rOk;
    bus.wr_en   = wr;
    bus.rd_en   = rd;
    bus.err_clr = clr;
    bus.din     = d;
    @(posedge clk);
    n   = q.size();
    wOk = wr && (n < DEPTH || rd);
    rOk = rd && (n > 0);
    if (wr && !wOk) ovfM = 1'b1;
    else if (clr) ovfM = 1'b0;
    if (rd && n == 0) udfM = 1'b1;
    else if (clr) udfM = 1'b0;
    if (rOk) void'(q.pop_front());
    if (wOk) q.push_back(d);
    #1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;
    bus.din     = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (actStatus() !== ResetStatus) begin
      bad++;
      $display("[TB] FAIL reset_status: got %b want %b", actStatus(), ResetStatus);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, W'(i));
      total++;
      if (actStatus() !== expStatus()) begin
        bad++;
        $display("[TB] FAIL fill_status[%0d]: got %b want %b", i, actStatus(), expStatus());
      end
      if (i == 1) begin
        total++;
        if ({bus.dout, bus.empty, bus.prog_empty} !== {32'd1, 1'b0, 1'b1}) begin
          bad++;
          $display("[TB] FAIL fill_first: got dout=%0d empty=%b pe=%b want 1/0/1",
                   bus.dout, bus.empty, bus.prog_empty);
        end
      end
      if (i == 3 || i == 4) begin
        total++;
        if (bus.prog_full !== (i == 4)) begin
          bad++;
          $display("[TB] FAIL fill_prog_full[%0d]: got %b want %b", i, bus.prog_full, i == 4);
        end
      end
      if (i == 6 || i == 7) begin
        total++;
        if (bus.nearly_full !== (i == 7)) begin
          bad++;
          $display("[TB] FAIL fill_nearly_full[%0d]: got %b want %b", i, bus.nearly_full, i == 7);
        end
      end
      if (i == 8) begin
        total++;
        if ({bus.full, bus.data_count} !== {1'b1, 4'd8}) begin
          bad++;
          $display("[TB] FAIL fill_full: got full=%b count=%0d want 1/8", bus.full, bus.data_count);
        end
      end
    end
  endtask

  task automatic test_overflow();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd9);
    total++;
    if ({bus.overflow, bus.data_count, bus.dout} !== {1'b1, 4'd8, 32'd1}) begin
      bad++;
      $display("[TB] FAIL overflow_set: got ovf=%b count=%0d dout=%0d want 1/8/1",
               bus.overflow, bus.data_count, bus.dout);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    total++;
    if (bus.overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL overflow_clear: got %b want 0", bus.overflow);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) begin
        total++;
        if (bus.dout !== W'(i)) begin
          bad++;
          $display("[TB] FAIL drain_dout[%0d]: got %0d want %0d", i, bus.dout, i);
        end
      end
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      total++;
      if (actStatus() !== expStatus()) begin
        bad++;
        $display("[TB] FAIL drain_status[%0d]: got %b want %b", i, actStatus(), expStatus());
      end
      if (i == 8) begin
        total++;
        if ({bus.empty, bus.underflow} !== 2'b10) begin
          bad++;
          $display("[TB] FAIL drain_empty: got empty=%b udf=%b want 1/0", bus.empty, bus.underflow);
        end
      end
    end
    total++;
    if ({bus.underflow, bus.data_count} !== {1'b1, 4'd0}) begin
      bad++;
      $display("[TB] FAIL drain_underflow: got udf=%b count=%0d want 1/0",
               bus.underflow, bus.data_count);
    end
  endtask

  task automatic test_rw_full();
    for (int v = 10; v <= 17; v++) applyStimulus(1'b1, 1'b0, 1'b0, W'(v));
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd18);
    total++;
    if ({bus.dout, bus.full, bus.data_count, bus.overflow} !== {32'd11, 1'b1, 4'd8, 1'b0}) begin
      bad++;
      $display("[TB] FAIL rw_full: got dout=%0d full=%b count=%0d ovf=%b want 11/1/8/0",
               bus.dout, bus.full, bus.data_count, bus.overflow);
    end
    total++;
    if (actStatus() !== expStatus()) begin
      bad++;
      $display("[TB] FAIL rw_full_status: got %b want %b", actStatus(), expStatus());
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] d;
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b1, '0);
    total++;
    if (actStatus() !== ResetStatus) begin
      bad++;
      $display("[TB] FAIL stream_start: got %b want %b", actStatus(), ResetStatus);
    end
    d = $urandom;
    applyStimulus(1'b1, 1'b0, 1'b0, d);
    for (int i = 0; i < 20; i++) begin
      d = $urandom;
      applyStimulus(1'b1, 1'b1, 1'b0, d);
      total++;
      if ({bus.data_count, bus.dout, bus.overflow, bus.underflow} !== {4'd1, d, 2'b00}) begin
        bad++;
        $display("[TB] FAIL stream[%0d]: got count=%0d dout=%h ovf=%b udf=%b want 1/%h/0/0",
                 i, bus.data_count, bus.dout, bus.overflow, bus.underflow, d);
      end
    end
  endtask

  task automatic test_async_reset();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, $urandom);
    total++;
    if ({bus.data_count, bus.underflow} !== {4'd5, 1'b1}) begin
      bad++;
      $display("[TB] FAIL areset_pre: got count=%0d udf=%b want 5/1", bus.data_count, bus.underflow);
    end
    #2;
    reset_n = 1'b0;
    #1;
    q.delete();
    ovfM = 1'b0;
    udfM = 1'b0;
    total++;
    if (actStatus() !== ResetStatus) begin
      bad++;
      $display("[TB] FAIL areset_now: got %b want %b", actStatus(), ResetStatus);
    end
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h5A5A_0001);
    total++;
    if ({bus.dout, bus.empty, bus.data_count} !== {32'h5A5A_0001, 1'b0, 4'd1}) begin
      bad++;
      $display("[TB] FAIL areset_first_write: got dout=%h empty=%b count=%0d want 5a5a0001/0/1",
               bus.dout, bus.empty, bus.data_count);
    end
  endtask

  task automatic test_random();
    logic wr, rd, clr;
    for (int i = 0; i < 400; i++) begin
      if ((i / 50) % 2 == 0) begin
        wr = ($urandom_range(0, 99) < 70);
        rd = ($urandom_range(0, 99) < 35);
      end else begin
        wr = ($urandom_range(0, 99) < 35);
        rd = ($urandom_range(0, 99) < 70);
      end
      clr = ($urandom_range(0, 15) == 0);
      applyStimulus(wr, rd, clr, $urandom);
      total++;
      if (actStatus() !== expStatus()) begin
        bad++;
        $display("[TB] FAIL random_status[%0d]: got %b want %b", i, actStatus(), expStatus());
      end
      if (q.size() > 0) begin
        total++;
        if (bus.dout !== q[0]) begin
          bad++;
          $display("[TB] FAIL random_dout[%0d]: got %h want %h", i, bus.dout, q[0]);
        end
      end
`ifdef FALLTHROUGH_FIFO_PARITY_EN
      total++;
      if (bus.parity_err !== 1'b0) begin
        bad++;
        $display("[TB] FAIL random_parity[%0d]: got %b want 0", i, bus.parity_err);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_rw_full();
    test_stream();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fallthrough_fifo_stat.md
Name: fallthrough_fifo_stat

Overview:
- Parametrised successor to the small fall-through FIFO used on the datapath queues.
- Head word is presented on dout whenever the FIFO is non-empty, so readers consume with a single rd_en pulse and no read latency.
- Adds over the previous generation:
  - programmable-empty threshold
  - live occupancy count
  - sticky overflow/underflow flags with clear
  - defined simultaneous read/write-at-full semantics
- Sits between packet-processing stages and module output queues.

Parameters:
- WIDTH, 72, data word width in bits.
- MAX_DEPTH_BITS, 3, log2 of depth; DEPTH = 2**MAX_DEPTH_BITS.
- PROG_FULL_THRESHOLD, DEPTH-1, prog_full asserts when count >= this value; legal range 1..DEPTH.
- PROG_EMPTY_THRESHOLD, 1, prog_empty asserts when count <= this value; legal range 0..DEPTH-1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- din  in  WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  pop head word.
- err_clr  in  1  clears sticky overflow/underflow.
- dout  out  WIDTH  head word; valid while empty=0.
- full  out  1  count == DEPTH.
- nearly_full  out  1  count >= DEPTH-1.
- prog_full  out  1  count >= PROG_FULL_THRESHOLD.
- empty  out  1  count == 0.
- prog_empty  out  1  count <= PROG_EMPTY_THRESHOLD.
- data_count  out  MAX_DEPTH_BITS+1  current occupancy 0..DEPTH.
- overflow  out  1  sticky: write rejected.
- underflow  out  1  sticky: read of empty FIFO.

Behaviour:
- Storage and pointers:
  - Storage is a DEPTH x WIDTH register array.
  - wr_ptr and rd_ptr are MAX_DEPTH_BITS wide and wrap modulo DEPTH.
  - count is MAX_DEPTH_BITS+1 wide.
- Reset (reset_n low, async):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0.
  - Outputs: empty=1, prog_empty=1, full=0, nearly_full=0, data_count=0.
  - prog_full=0 (PROG_FULL_THRESHOLD >= 1).
  - dout is don't-care while empty; array contents are not cleared.
  - Reset mid-operation discards all contents immediately.
- Flags:
  - All status flags are combinational decodes of the registered count.
  - They therefore update in the cycle after the causing edge.
- Accepted write: wr_en=1 and (count<DEPTH, or rd_en=1 with count==DEPTH). The word is stored at wr_ptr and wr_ptr increments.
- Accepted read: rd_en=1 and count>0. rd_ptr increments.
- Fall-through:
  - dout = mem[rd_ptr], combinational from the array.
  - A word written into an empty FIFO appears on dout with empty=0 one cycle after its write edge.
  - There is no bypass from din to dout in the same cycle.
- Simultaneous read and write:
  - count==0: only the write is accepted; the read sets underflow.
  - 0<count<DEPTH: both are accepted and count is unchanged.
  - count==DEPTH: both are accepted and full stays asserted.
- Rejected write (wr_en=1, full, rd_en=0): word dropped, pointers unchanged, overflow<=1.
- Rejected read (rd_en=1, empty): no state change, underflow<=1.
- Sticky errors:
  - err_clr=1 clears both flags on the next edge.
  - A new error in the same cycle as err_clr wins, so the flag stays 1.
- Count update: count += accepted_write - accepted_read. It never exceeds DEPTH and never goes below 0.

Optional Feature:
- Macro: FALLTHROUGH_FIFO_PARITY_EN.
- When defined:
  - Each entry stores one extra even-parity bit computed over din at write.
  - A port parity_err (out, 1) is added. It is a combinational compare of stored parity against the XOR of dout, qualified by !empty.
  - Array width becomes WIDTH+1.
- When undefined:
  - No parity storage and no parity_err port.
  - Behaviour is otherwise identical.

Test Plan:
- Use WIDTH=32, MAX_DEPTH_BITS=3, PROG_FULL_THRESHOLD=4, PROG_EMPTY_THRESHOLD=1 throughout.
- Reset then fill: hold reset_n=0 for 2 cycles, then write 1..8 on consecutive cycles.
  - After the 1st write edge: dout=1, empty=0, prog_empty=1.
  - After the 4th write edge: prog_full=1.
  - After the 7th write edge: nearly_full=1.
  - After the 8th write edge: full=1, data_count=8.
- Overflow: with the FIFO full, write 9 with rd_en=0.
  - Result: overflow=1, data_count=8, dout=1.
  - Pulse err_clr: overflow=0.
- Drain and underflow: assert rd_en for 9 cycles.
  - dout sequences 1..8.
  - empty=1 after the 8th pop; the 9th pop sets underflow=1.
  - data_count=0.
- Read and write at full: refill with 10..17, then assert wr_en=1 (din=18) and rd_en=1 together.
  - Accepted: dout becomes 11, full stays 1, data_count=8, overflow=0.
- Streaming with wrap: from empty, apply 20 cycles of simultaneous wr/rd starting with one lead write.
  - data_count stays 1.
  - dout follows din delayed by one cycle across pointer wrap.
  - No error flags.
- Async reset mid-stream: drop reset_n between clock edges with data_count=5.
  - Immediately: empty=1, data_count=0, overflow and underflow cleared.
  - The first write after release appears on dout next cycle.
